// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
// Shared constants for the RV32I multi-cycle control sequencer:
// opcode values (inst[6:2]), FSM state encoding, mux-select encodings,
// trap causes, the default memory-handshake timeout and the decode
// helper functions used by core_ctrl.
package core_ctrl_pkg;

    // Opcodes as seen on inst[6:2]
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_OPIMM   = 5'b00100;
    localparam logic [4:0] OP_OP      = 5'b01100;
    localparam logic [4:0] OP_MISCMEM = 5'b00011;

    // FSM state encoding (6 is unused)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Opcode/func3 combinations the core can execute.
    function automatic logic is_legal(input logic [4:0] op, input logic [2:0] f3);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL,
            OP_OPIMM, OP_OP, OP_MISCMEM: return 1'b1;
            OP_JALR:   return (f3 == 3'b000);
            OP_BRANCH: return !((f3 == 3'b010) || (f3 == 3'b011));
            OP_LOAD:   return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
            OP_STORE:  return (f3 <= 3'b010);
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_sel_for(input logic [4:0] op);
        case (op)
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            OP_BRANCH:        return IMM_B;
            OP_STORE:         return IMM_S;
            default:          return IMM_I;
        endcase
    endfunction

    function automatic logic [1:0] wb_sel_for(input logic [4:0] op);
        case (op)
            OP_LOAD:         return WB_MEM;
            OP_JAL, OP_JALR: return WB_PC4;
            OP_LUI:          return WB_IMM;
            default:         return WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// core_ctrl_if
// Instruction- and data-memory handshake bundle between the control
// sequencer (master) and the memory side (slave).
//   imem_req  master->slave  instruction fetch request
//   imem_ack  slave->master  fetch data valid / request accepted
//   dmem_req  master->slave  data memory request
//   dmem_we   master->slave  1 = store, 0 = load (valid while dmem_req)
//   dmem_ack  slave->master  data memory done
interface core_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/core_ctrl_handshake_timer.sv
// handshake_timer
// Counts consecutive cycles a memory request is outstanding without an
// acknowledge. One instance serves both imem and dmem because the core
// never has both requests up at once.
//   clk      core clock
//   rst      asynchronous active-low reset
//   req      a memory request is high this cycle
//   ack      the request is acknowledged this cycle
//   clr      controller state is changing; restart the count
//   expired  this is the LIMIT-th unacknowledged request cycle
module handshake_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    input  logic clr,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !req || ack) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // cnt_q holds the number of earlier waiting cycles, so the request
    // has been up LIMIT cycles when cnt_q reaches LIMIT-1.
    assign expired = req && !ack && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/core_ctrl.sv
// core_ctrl
// Multi-cycle control sequencer for an RV32I core:
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH/IDLE, with a
// terminal TRAP state for illegal instructions and memory timeouts.
// Ports:
//   clk, rst            core clock; asynchronous active-low reset
//   run                 core enable, sampled at instruction boundaries
//   mem                 imem/dmem handshake (core_ctrl_if.master)
//   opcode, func3       from decode; held by the IR until the next ir_we
//   branch_taken        ALU compare result for the current branch
//   ir_we, pc_we        IR load strobe; PC update (one per retired inst)
//   pc_sel, imm_sel     next-PC and immediate format selects
//   alu_a_sel/b_sel     ALU operand selects (pc / imm)
//   rf_we, wb_sel       register write enable and writeback source
//   state               current FSM state (debug)
//   trap, trap_cause    sticky trap flag and its cause
// Optional: define CORE_CTRL_PERF_CNT_EN to add cycle_cnt / instret_cnt.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    core_ctrl_if.master mem,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        branch_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef CORE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    logic [2:0] state_q, state_d;
    logic [1:0] cause_q, cause_d;

    logic imem_req_c;
    logic dmem_req_c;
    logic dmem_we_c;
    logic tmr_expired;
    logic tmr_ack;

    logic [2:0] boundary_state;
    logic       is_mem_op;

    assign boundary_state = run ? ST_FETCH : ST_IDLE;
    assign is_mem_op      = (opcode == OP_LOAD) || (opcode == OP_STORE);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        imm_sel    = IMM_I;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;

        // Operand selects stay valid from EXEC through MEM and WB so the
        // ALU result (address or writeback value) is stable when consumed.
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            alu_a_sel = (opcode == OP_AUIPC) || (opcode == OP_JAL);
            alu_b_sel = !((opcode == OP_OP) || (opcode == OP_BRANCH));
        end
        if (state_q == ST_DECODE || state_q == ST_EXEC ||
            state_q == ST_MEM || state_q == ST_WB) begin
            imm_sel = imm_sel_for(opcode);
        end

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (!is_legal(opcode, func3)) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (opcode == OP_MISCMEM) begin
                    pc_we   = 1'b1;
                    state_d = boundary_state;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_REL : PC_PLUS4;
                    state_d = boundary_state;
                end else if (is_mem_op) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OP_STORE);
                if (mem.dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_we   = 1'b1;
                        state_d = boundary_state;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = wb_sel_for(opcode);
                if (opcode == OP_JAL) begin
                    pc_sel = PC_REL;
                end else if (opcode == OP_JALR) begin
                    pc_sel = PC_JALR;
                end
                state_d = boundary_state;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Only one request is ever up, so the ack that matters follows the state.
    assign tmr_ack = (state_q == ST_FETCH) ? mem.imem_ack : mem.dmem_ack;

    handshake_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (imem_req_c || dmem_req_c),
        .ack     (tmr_ack),
        .clr     (state_d != state_q),
        .expired (tmr_expired)
    );

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign state        = state_q;
    assign trap         = (state_q == ST_TRAP);
    assign trap_cause   = cause_q;

`ifdef CORE_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != ST_IDLE && state_q != ST_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (pc_we) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Drives instruction fetch handshake and the instruction-register load.
- Consumes opcode/func3 from the decode stage; selects which decode immediate (I/S/B/U/J) feeds the datapath.
- Sequences ALU, data-memory and writeback enables, and traps on illegal instructions and memory handshake timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles a memory request may stay unacknowledged before a trap (range 2..255).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- run  in  1  core enable, sampled at instruction boundary
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid / request accepted
- opcode  in  5  inst[6:2] from decode
- func3  in  3  from decode
- branch_taken  in  1  ALU compare result for current branch
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
- dmem_ack  in  1  data memory done
- ir_we  out  1  load instruction register
- pc_we  out  1  PC update strobe, one pulse per retired instruction
- pc_sel  out  2  00 pc+4, 01 pc+imm (branch taken/JAL), 10 rs1+imm (JALR)
- imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J
- alu_a_sel  out  1  0 rs1, 1 pc
- alu_b_sel  out  1  0 rs2, 1 imm
- rf_we  out  1  register file write enable
- wb_sel  out  2  00 alu, 01 mem data, 10 pc+4, 11 imm
- state  out  3  current FSM state (debug)
- trap  out  1  sticky trap flag
- trap_cause  out  2  00 none, 01 illegal inst, 10 imem timeout, 11 dmem timeout

Behaviour:
Reset (rst=0, async)
- State goes to IDLE. All outputs 0. Timeout counter cleared.
- Reset in any state, including mid-handshake, drops imem_req/dmem_req immediately.

States
- IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- IDLE: run=1 -> FETCH next cycle.
- FETCH: imem_req=1, held until imem_ack is sampled high.
  - ir_we=1 in the ack cycle; go to DECODE.
  - ack without req is ignored.
- DECODE: sets imm_sel for the opcode.
  - Opcodes: LUI 01101, AUIPC 00101, JAL 11011, JALR 11001, BRANCH 11000, LOAD 00000, STORE 01000, OP-IMM 00100, OP 01100, MISC-MEM 00011.
  - MISC-MEM: NOP, pc_we=1, go to FETCH.
  - Any other opcode (including SYSTEM) -> TRAP, cause 01.
  - Also illegal: LOAD with func3 011/110/111; STORE with func3 >010; BRANCH with func3 010/011; JALR with func3 !=000.
- EXEC:
  - alu_a_sel=1 for AUIPC/JAL.
  - alu_b_sel=1 for all except OP and BRANCH.
  - BRANCH retires here: pc_we=1, pc_sel=01 if branch_taken else 00, then FETCH.
  - LOAD/STORE -> MEM; all others -> WB.
- MEM: dmem_req=1, dmem_we=1 for STORE, held until dmem_ack.
  - STORE retires in the ack cycle (pc_we=1, pc_sel=00) -> FETCH.
  - LOAD -> WB.
- WB: rf_we=1, pc_we=1, then FETCH (or IDLE if run=0).
  - wb_sel: LOAD 01, JAL/JALR 10, LUI 11, else 00.
  - pc_sel: JAL 01, JALR 10, else 00.
- Minimum latency with zero-wait ack: ALU ops 4 cycles, load 5, store 4, branch 3.
- run=0 mid-instruction: current instruction completes; FSM goes to IDLE instead of FETCH.

Timeout
- A counter runs while any req is high without ack.
- If TIMEOUT_CYCLES cycles elapse without ack -> TRAP with cause 10 (imem) or 11 (dmem); req drops on entry.
- The counter clears on ack or on state change.

TRAP
- Terminal until reset. trap=1, cause held, all enables 0.
- pc_we is never asserted for the trapping instruction.

Optional Feature:
- Macro CORE_CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle the state is not IDLE/TRAP.
  - instret_cnt increments on each pc_we.
  - Both wrap 0xFFFFFFFF -> 0 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package core_ctrl_pkg holds:
  - opcode constants
  - state encoding
  - imm_sel / wb_sel / pc_sel / trap_cause encodings
  - default TIMEOUT_CYCLES
- One sub-module, handshake_timer: counter plus expiry flag.
  - Single instance shared by imem and dmem, since the two requests are never concurrent.

Test Plan:
- ADDI x1,x0,5 (opcode 00100), imem_ack same cycle as req -> FETCH,DECODE,EXEC,WB; imm_sel=0, alu_b_sel=1, rf_we=1 and pc_we=1 in cycle 4.
- LW (00000, func3 010), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0; then WB with wb_sel=01, rf_we=1.
- BEQ (11000, func3 000), branch_taken=1 -> pc_we=1, pc_sel=01, imm_sel=2 in EXEC; rf_we never asserted.
- SYSTEM opcode 11100 -> DECODE to TRAP; trap=1, trap_cause=01, pc_we stays 0 for 20 further cycles.
- imem_ack held 0 with TIMEOUT_CYCLES=16 -> imem_req high 16 cycles, then TRAP with cause 10.
- rst low during MEM of a store -> same-cycle dmem_req=0 and state=IDLE; after release with run=1 -> FETCH.
